cp0_exc: RTL

Coprocessor-0 register file and exception arbiter for the MangoMIPS32 5-stage pipeline. It sits beside the MEM/WB boundary and is the producer side of the exception interface. Each cycle it prioritises the exception flags of the instruction in MEM against pending interrupts. It then drives `exc_flag`, `exc_type`, `cp0_EPC` and `cp0_Status` to the pipeline controller, which performs the flush and redirect. It holds the architectural Count, Compare, Status, Cause, EPC, BadVAddr, PRId and Config registers, serves MFC0/MTC0, and generates the timer interrupt.

---
 rtl/cp0_exc.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/cp0_exc.sv
// CP0 register file and exception arbiter for the MangoMIPS32 pipeline.
// Prioritises the MEM-stage exception flags against pending interrupts and keeps the CP0 state.
module cp0_exc #(
   parameter logic [31:0] PRID   = 32'h0001_8000,
   parameter logic [31:0] CONFIG = 32'h8000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [5:0]  intr,
   input  logic        wb_cp0_we,
   input  logic [4:0]  wb_cp0_addr,
   input  logic [31:0] wb_cp0_wdata,
   input  logic [4:0]  rd_addr,
   output logic [31:0] rd_data,
   input  logic        mem_valid,
   input  logic [31:0] mem_pc,
   input  logic        mem_bd,
   input  logic [31:0] mem_vaddr,
   input  logic [9:0]  mem_exc,
   output logic        exc_flag,
   output logic [4:0]  exc_type,
   output logic [31:0] cp0_EPC,
   output logic [31:0] cp0_Status,
   output logic [31:0] cp0_Cause,
   output logic        timer_int
);

   localparam logic [4:0] A_BADVADDR = 5'd8;
   localparam logic [4:0] A_COUNT    = 5'd9;
   localparam logic [4:0] A_COMPARE  = 5'd11;
   localparam logic [4:0] A_STATUS   = 5'd12;
   localparam logic [4:0] A_CAUSE    = 5'd13;
   localparam logic [4:0] A_EPC      = 5'd14;
   localparam logic [4:0] A_PRID     = 5'd15;
   localparam logic [4:0] A_CONFIG   = 5'd16;

   localparam logic [31:0] STATUS_WMASK = 32'h0040_FF07;
   localparam logic [31:0] CAUSE_WMASK  = 32'h0080_0300;
   localparam logic [31:0] STATUS_RST   = 32'h0040_0004;

   localparam logic [4:0] EX_INT  = 5'h00;
   localparam logic [4:0] EX_ADEL = 5'h04;
   localparam logic [4:0] EX_ADES = 5'h05;
   localparam logic [4:0] EX_SYS  = 5'h08;
   localparam logic [4:0] EX_BP   = 5'h09;
   localparam logic [4:0] EX_RI   = 5'h0A;
   localparam logic [4:0] EX_CPU  = 5'h0B;
   localparam logic [4:0] EX_OV   = 5'h0C;
   localparam logic [4:0] EX_TRAP = 5'h0D;
   localparam logic [4:0] EX_ERET = 5'h10;

   logic [31:0] status_q, status_d, cause_q, cause_d, epc_q, epc_d;
   logic [31:0] badvaddr_q, badvaddr_d, count_q, count_d, compare_q, compare_d;
   logic        toggle_q, toggle_d;

   logic        wr_status_s, wr_cause_s, wr_epc_s, wr_count_s, wr_compare_s;
   logic [31:0] status_fwd_s, cause_fwd_s, epc_fwd_s;
   logic        int_req_s, eret_sel_s, flag_s, taken_exc_s, taken_eret_s;
   logic [4:0]  type_s;

   // MTC0 in WB is older than the MEM instruction, so its masked value is forwarded
   always_comb begin
      wr_status_s  = wb_cp0_we && (wb_cp0_addr == A_STATUS);
      wr_cause_s   = wb_cp0_we && (wb_cp0_addr == A_CAUSE);
      wr_epc_s     = wb_cp0_we && (wb_cp0_addr == A_EPC);
      wr_count_s   = wb_cp0_we && (wb_cp0_addr == A_COUNT);
      wr_compare_s = wb_cp0_we && (wb_cp0_addr == A_COMPARE);
      status_fwd_s = wr_status_s ? (wb_cp0_wdata & STATUS_WMASK) : status_q;
      cause_fwd_s  = wr_cause_s ? ((cause_q & ~CAUSE_WMASK) | (wb_cp0_wdata & CAUSE_WMASK)) : cause_q;
      epc_fwd_s    = wr_epc_s ? wb_cp0_wdata : epc_q;
      int_req_s    = status_fwd_s[0] & ~status_fwd_s[1] & ~status_fwd_s[2] &
                     (|(cause_fwd_s[15:8] & status_fwd_s[15:8]));
   end

   // Fixed-priority arbitration of interrupt against the MEM exception flags
   always_comb begin
      eret_sel_s = 1'b0;
      type_s     = EX_INT;
      if (int_req_s)       type_s = EX_INT;
      else if (mem_exc[0]) type_s = EX_ADEL;
      else if (mem_exc[1]) type_s = EX_RI;
      else if (mem_exc[2]) type_s = EX_CPU;
      else if (mem_exc[3]) type_s = EX_OV;
      else if (mem_exc[4]) type_s = EX_TRAP;
      else if (mem_exc[5]) type_s = EX_SYS;
      else if (mem_exc[6]) type_s = EX_BP;
      else if (mem_exc[7]) type_s = EX_ADEL;
      else if (mem_exc[8]) type_s = EX_ADES;
      else if (mem_exc[9]) begin
         type_s     = EX_ERET;
         eret_sel_s = 1'b1;
      end else begin
         type_s     = EX_INT;
         eret_sel_s = 1'b0;
      end
      flag_s       = ~rst & mem_valid & (int_req_s | (|mem_exc));
      taken_exc_s  = flag_s & ~eret_sel_s;
      taken_eret_s = flag_s & eret_sel_s;
   end

   // Next-state: MTC0 effects first, then timer, then exception/ERET overrides
   always_comb begin
      status_d   = status_fwd_s;
      cause_d    = cause_fwd_s;
      epc_d      = epc_fwd_s;
      badvaddr_d = badvaddr_q;
      compare_d  = wr_compare_s ? wb_cp0_wdata : compare_q;
      if (wr_count_s) begin
         count_d  = wb_cp0_wdata;
         toggle_d = 1'b0;
      end else begin
         count_d  = count_q + {31'd0, toggle_q};
         toggle_d = ~toggle_q;
      end
      if (wr_compare_s)               cause_d[30] = 1'b0;
      else if (count_q == compare_q)  cause_d[30] = 1'b1;
      else                            cause_d[30] = cause_q[30];
      cause_d[15:10] = {intr[5] | cause_q[30], intr[4:0]};
      if (taken_exc_s) begin
         if (!status_fwd_s[1]) begin
            epc_d       = mem_bd ? (mem_pc - 32'd4) : mem_pc;
            cause_d[31] = mem_bd;
         end else begin
            epc_d       = epc_fwd_s;
            cause_d[31] = cause_fwd_s[31];
         end
         status_d[1]   = 1'b1;
         cause_d[6:2]  = type_s;
         if ((type_s == EX_ADEL) && mem_exc[0])                 badvaddr_d = mem_pc;
         else if ((type_s == EX_ADEL) || (type_s == EX_ADES))   badvaddr_d = mem_vaddr;
         else                                                   badvaddr_d = badvaddr_q;
      end else if (taken_eret_s) begin
         if (status_fwd_s[2]) status_d[2] = 1'b0;
         else                 status_d[1] = 1'b0;
      end else begin
         status_d = status_fwd_s;
      end
   end

   // CP0 state registers
   always_ff @(posedge clk) begin
      if (rst) begin
         status_q   <= STATUS_RST;
         cause_q    <= 32'd0;
         epc_q      <= 32'd0;
         badvaddr_q <= 32'd0;
         count_q    <= 32'd0;
         compare_q  <= 32'd0;
         toggle_q   <= 1'b0;
      end else begin
         status_q   <= status_d;
         cause_q    <= cause_d;
         epc_q      <= epc_d;
         badvaddr_q <= badvaddr_d;
         count_q    <= count_d;
         compare_q  <= compare_d;
         toggle_q   <= toggle_d;
      end
   end

   // MFC0 read mux
   always_comb begin
      case (rd_addr)
         A_BADVADDR: rd_data = badvaddr_q;
         A_COUNT:    rd_data = count_q;
         A_COMPARE:  rd_data = compare_q;
         A_STATUS:   rd_data = status_fwd_s;
         A_CAUSE:    rd_data = cause_fwd_s;
         A_EPC:      rd_data = epc_fwd_s;
         A_PRID:     rd_data = PRID;
         A_CONFIG:   rd_data = CONFIG;
         default:    rd_data = 32'd0;
      endcase
   end

   assign exc_flag   = flag_s;
   assign exc_type   = flag_s ? type_s : 5'h00;
   assign cp0_EPC    = epc_fwd_s;
   assign cp0_Status = status_fwd_s;
   assign cp0_Cause  = cause_fwd_s;
   assign timer_int  = cause_q[30];

endmodule
